// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers for the countdown timers: maximal-length tap table,
// width selection and constant-time state stepping used at elaboration.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W     = 32;
  localparam int unsigned LFSR_COUNT_MAX = 32'd2147483646;

  // Feedback tap masks (bit t-1 set for tap t), maximal length for W = 2..32
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    logic [31:0] t;
    t = 32'h0000_0003;
    case (w)
      2:  t = 32'h0000_0003;
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0000_0003;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] lfsr_mask(input int unsigned w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  // Smallest W >= 2 whose sequence is long enough to hold COUNT+1 distinct states
  function automatic int unsigned lfsr_width(input int unsigned count);
    int unsigned w;
    w = 2;
    while ((w < LFSR_MAX_W) && (((64'd1 << w) - 64'd1) < (64'(count) + 64'd1)))
      w = w + 1;
    return w;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input int unsigned w);
    return ((state << 1) | 32'(^(state & lfsr_taps(w)))) & lfsr_mask(w);
  endfunction

  function automatic logic [31:0] lfsr_advance(input logic [31:0] seed, input int unsigned n,
                                               input int unsigned w);
    logic [31:0] s;
    s = seed & lfsr_mask(w);
    for (int unsigned i = 0; i < n; i++)
      s = lfsr_next(s, w);
    return s;
  endfunction

endpackage

// File: rtl/lfsr_timer_ch.sv
// One LFSR countdown channel: terminal is detected one step early so tick and
// done register on the very edge the COUNT-th enabled cycle completes.
module lfsr_timer_ch
  import lfsr_pkg::*;
#(
  parameter int unsigned COUNT = 100
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_restart,
  input  logic i_periodic,
  output logic o_done,
  output logic o_tick
);

  localparam int unsigned W         = lfsr_width(COUNT);
  localparam logic [W-1:0] SEED      = '1;
  localparam logic [W-1:0] TERM_PREV = W'(lfsr_advance(32'hFFFF_FFFF, COUNT - 1, W));
  localparam logic [W-1:0] TERM      = W'(lfsr_next(32'(TERM_PREV), W));

  logic [W-1:0] state_q, state_d;
  logic         done_d, tick_d;
  logic         frozen_c;

  // A one-shot channel parks on TERM; periodic operation never reaches it
  always_comb begin
    state_d  = state_q;
    done_d   = o_done;
    tick_d   = 1'b0;
    frozen_c = (state_q == TERM);
    if (i_restart) begin
      state_d = SEED;
      done_d  = 1'b0;
    end else if (i_enable && !frozen_c) begin
      if (state_q == TERM_PREV) begin
        tick_d  = 1'b1;
        done_d  = 1'b1;
        state_d = i_periodic ? SEED : TERM;
      end else begin
        state_d = W'(lfsr_next(32'(state_q), W));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= SEED;
      o_done  <= 1'b0;
      o_tick  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_done  <= done_d;
      o_tick  <= tick_d;
    end
  end

endmodule

// File: rtl/lfsr_timer_bank.sv
// Bank of NCH independent LFSR countdown timers sharing one terminal count.
module lfsr_timer_bank
  import lfsr_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned COUNT = 100
) (
  input  logic           clock,
  input  logic           i_reset,
  input  logic [NCH-1:0] i_enable,
  input  logic [NCH-1:0] i_restart,
  input  logic [NCH-1:0] i_periodic,
  output logic [NCH-1:0] o_done,
  output logic [NCH-1:0] o_tick
);

  if ((COUNT == 0) || (COUNT > LFSR_COUNT_MAX)) begin : g_bad_count
    $error("lfsr_timer_bank: COUNT=%0d outside 1..%0d", COUNT, LFSR_COUNT_MAX);
  end
  if (NCH == 0) begin : g_bad_nch
    $error("lfsr_timer_bank: NCH must be at least 1");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    lfsr_timer_ch #(
      .COUNT(COUNT)
    ) u_ch (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_enable  (i_enable[c]),
      .i_restart (i_restart[c]),
      .i_periodic(i_periodic[c]),
      .o_done    (o_done[c]),
      .o_tick    (o_tick[c])
    );
  end

endmodule

// File: tb/tb_lfsr_timer_bank.sv
// Scoreboard bench: several banks with different COUNT share one stimulus
// stream; a per-channel enabled-cycle counter model predicts done/tick.
module tb_lfsr_timer_bank;

  localparam int unsigned NCH   = 4;
  localparam int unsigned NINST = 7;

  function automatic int unsigned cnt_of(input int unsigned g);
    case (g)
      0:       return 100;
      1:       return 1;
      2:       return 2;
      3:       return 3;
      4:       return 126;
      5:       return 127;
      default: return 128;
    endcase
  endfunction

  logic           clock;
  logic           i_reset;
  logic [NCH-1:0] i_enable, i_restart, i_periodic;
  logic [NCH-1:0] done_w [NINST];
  logic [NCH-1:0] tick_w [NINST];

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    lfsr_timer_bank #(
      .NCH  (NCH),
      .COUNT(cnt_of(g))
    ) u_dut (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_enable  (i_enable),
      .i_restart (i_restart),
      .i_periodic(i_periodic),
      .o_done    (done_w[g]),
      .o_tick    (tick_w[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [NCH-1:0] done [NINST];
    logic [NCH-1:0] tick [NINST];
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned m_e      [NINST][NCH];
  bit          m_done   [NINST][NCH];
  bit          m_tick   [NINST][NCH];
  bit          m_frozen [NINST][NCH];

  // Drive one cycle of inputs and push the outputs expected after the next edge
  task automatic step(input logic rst, input logic [NCH-1:0] en,
                      input logic [NCH-1:0] rs, input logic [NCH-1:0] per);
    exp_t x;
    @(negedge clock);
    i_reset    = rst;
    i_enable   = en;
    i_restart  = rs;
    i_periodic = per;
    for (int g = 0; g < NINST; g++) begin
      for (int c = 0; c < NCH; c++) begin
        if (rst || rs[c]) begin
          m_e[g][c]      = 0;
          m_done[g][c]   = 1'b0;
          m_tick[g][c]   = 1'b0;
          m_frozen[g][c] = 1'b0;
        end else begin
          m_tick[g][c] = 1'b0;
          if (en[c] && !m_frozen[g][c]) begin
            m_e[g][c] = m_e[g][c] + 1;
            if (m_e[g][c] == cnt_of(g)) begin
              m_tick[g][c] = 1'b1;
              m_done[g][c] = 1'b1;
              if (per[c]) m_e[g][c] = 0;
              else        m_frozen[g][c] = 1'b1;
            end
          end
        end
        x.done[g][c] = m_done[g][c];
        x.tick[g][c] = m_tick[g][c];
      end
    end
    sb_q.push_back(x);
  endtask

  // Monitor: compare every channel of every bank once per clock
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        for (int g = 0; g < NINST; g++) begin
          for (int c = 0; c < NCH; c++) begin
            checks++;
            if (done_w[g][c] !== x.done[g][c]) begin
              errors++;
              $display("FAIL done count=%0d ch%0d t=%0t got %b want %b",
                       cnt_of(g), c, $time, done_w[g][c], x.done[g][c]);
            end
            checks++;
            if (tick_w[g][c] !== x.tick[g][c]) begin
              errors++;
              $display("FAIL tick count=%0d ch%0d t=%0t got %b want %b",
                       cnt_of(g), c, $time, tick_w[g][c], x.tick[g][c]);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [NCH-1:0] en, rs, per;
    i_reset    = 1'b1;
    i_enable   = '0;
    i_restart  = '0;
    i_periodic = '0;
    repeat (3) step(1'b1, '0, '0, '0);

    // ch0 one-shot late enable, ch1 random enable, ch2 periodic, ch3 restarts
    for (int t = 0; t < 560; t++) begin
      en    = '0;
      en[0] = (t >= 10);
      en[1] = 1'($urandom_range(0, 1));
      en[2] = 1'b1;
      en[3] = 1'b1;
      rs    = '0;
      rs[3] = (t == 57) || (t == 300);
      per   = 4'b0100;
      step(1'b0, en, rs, per);
    end

    // Reset in the middle of counting
    for (int t = 0; t < 80; t++)
      step((t == 40) || (t == 41), 4'hF, '0, 4'hA);

    // Random enables, rare restarts/resets and mode changes
    per = 4'b0101;
    for (int t = 0; t < 2200; t++) begin
      for (int c = 0; c < NCH; c++) begin
        en[c] = ($urandom_range(0, 3) != 0);
        rs[c] = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 63) == 0) per[c] = ~per[c];
      end
      step(($urandom_range(0, 999) == 0), en, rs, per);
    end

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
